// File: rtl/mem_ctrl.sv
// mem_ctrl: fetch (24-bit) and data (16-bit) read ports with handshakes, plus a
// single-cycle byte-enabled write port, over one 16-bit RAM + ROM address map.
`default_nettype none

module mem_ctrl #(
    parameter int          RAMADDRBITS = 10,
    parameter logic [15:0] RAMBASE     = 16'h0000,
    parameter int          ROMSIZE     = 2048,
    parameter logic [15:0] ROMBASE     = 16'h4000,
    parameter int          ROMWAIT     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iread_req,
    output logic        iread_ready,
    input  logic [15:0] iread_addr,
    output logic [23:0] iread_data,
    output logic        iread_valid,
    output logic        iread_err,
    input  logic        dread_req,
    output logic        dread_ready,
    input  logic [15:0] dread_addr,
    output logic [15:0] dread_data,
    output logic        dread_valid,
    output logic        dread_err,
    input  logic [15:0] dwrite_addr,
    input  logic [15:0] dwrite_data,
    input  logic [1:0]  dwrite_en,
    output logic        dwrite_err
);

    localparam int       RAMSIZE = 1 << RAMADDRBITS;
    localparam logic [2:0] WAIT_LD = (ROMWAIT > 0) ? 3'(ROMWAIT - 1) : 3'd0;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    function automatic logic in_ram(input logic [15:0] a);
        return {1'b0, 16'(a - RAMBASE)} < 17'(RAMSIZE);
    endfunction

    function automatic logic in_rom(input logic [15:0] a);
        return {1'b0, 16'(a - ROMBASE)} < 17'(ROMSIZE);
    endfunction

    function automatic logic [RAMADDRBITS-1:0] ram_idx(input logic [15:0] a);
        return RAMADDRBITS'(a - RAMBASE);
    endfunction

    // Fixed ROM image: byte at offset o is o[7:0] ^ o[10:8] ^ 8'hA5.
    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        return 8'(a - ROMBASE) ^ {5'b0, 3'((a - ROMBASE) >> 8)} ^ 8'hA5;
    endfunction

    logic [7:0]  mem_q [RAMSIZE];

    state_t      i_state_q, i_state_d, d_state_q, d_state_d;
    logic [2:0]  i_cnt_q, i_cnt_d, d_cnt_q, d_cnt_d;
    logic [15:0] i_addr_q, i_addr_d, d_addr_q, d_addr_d;
    logic [23:0] i_data_q, i_data_d;
    logic [15:0] d_data_q, d_data_d;
    logic        i_err_q, i_err_d, d_err_q, d_err_d;
    logic        werr_q, werr_d;

    logic [15:0] w_wa1, w_isa, w_dsa;
    logic [15:0] w_la [5];
    logic [7:0]  w_lb [5];
    logic [4:0]  w_lerr, w_lrom;

    assign w_wa1 = dwrite_addr + 16'd1;
    // Outside BUSY the live request address is decoded so zero-wait accesses sample at accept.
    assign w_isa = (i_state_q == BUSY) ? i_addr_q : iread_addr;
    assign w_dsa = (d_state_q == BUSY) ? d_addr_q : dread_addr;
    assign w_la[0] = w_isa;
    assign w_la[1] = w_isa + 16'd1;
    assign w_la[2] = w_isa + 16'd2;
    assign w_la[3] = w_dsa;
    assign w_la[4] = w_dsa + 16'd1;

    always_comb begin
        for (int k = 0; k < 5; k++) begin
            w_lb[k]   = 8'h00;
            w_lerr[k] = 1'b0;
            w_lrom[k] = 1'b0;
            if (in_ram(w_la[k])) begin
                w_lb[k] = mem_q[ram_idx(w_la[k])];
                if (dwrite_en[0] && dwrite_addr == w_la[k])
                    w_lb[k] = dwrite_data[7:0];
                else if (dwrite_en[1] && w_wa1 == w_la[k])
                    w_lb[k] = dwrite_data[15:8];
            end else if (in_rom(w_la[k])) begin
                w_lb[k]   = rom_byte(w_la[k]);
                w_lrom[k] = 1'b1;
            end else begin
                w_lerr[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (dwrite_en[0] && in_ram(dwrite_addr))
            mem_q[ram_idx(dwrite_addr)] <= dwrite_data[7:0];
        if (dwrite_en[1] && in_ram(w_wa1))
            mem_q[ram_idx(w_wa1)] <= dwrite_data[15:8];
    end

    assign werr_d = (dwrite_en[0] && !in_ram(dwrite_addr)) || (dwrite_en[1] && !in_ram(w_wa1));

    always_comb begin
        i_state_d = i_state_q;
        i_cnt_d   = i_cnt_q;
        i_addr_d  = i_addr_q;
        i_data_d  = i_data_q;
        i_err_d   = i_err_q;
        case (i_state_q)
            BUSY: begin
                if (i_cnt_q == 3'd0) begin
                    i_state_d = DONE;
                    i_data_d  = {w_lb[2], w_lb[1], w_lb[0]};
                    i_err_d   = |w_lerr[2:0];
                end else begin
                    i_cnt_d = i_cnt_q - 3'd1;
                end
            end
            default: begin
                i_state_d = IDLE;
                if (iread_req) begin
                    i_addr_d = iread_addr;
                    if ((|w_lrom[2:0]) && ROMWAIT > 0) begin
                        i_state_d = BUSY;
                        i_cnt_d   = WAIT_LD;
                    end else begin
                        i_state_d = DONE;
                        i_data_d  = {w_lb[2], w_lb[1], w_lb[0]};
                        i_err_d   = |w_lerr[2:0];
                    end
                end
            end
        endcase
    end

    always_comb begin
        d_state_d = d_state_q;
        d_cnt_d   = d_cnt_q;
        d_addr_d  = d_addr_q;
        d_data_d  = d_data_q;
        d_err_d   = d_err_q;
        case (d_state_q)
            BUSY: begin
                if (d_cnt_q == 3'd0) begin
                    d_state_d = DONE;
                    d_data_d  = {w_lb[4], w_lb[3]};
                    d_err_d   = |w_lerr[4:3];
                end else begin
                    d_cnt_d = d_cnt_q - 3'd1;
                end
            end
            default: begin
                d_state_d = IDLE;
                if (dread_req) begin
                    d_addr_d = dread_addr;
                    if ((|w_lrom[4:3]) && ROMWAIT > 0) begin
                        d_state_d = BUSY;
                        d_cnt_d   = WAIT_LD;
                    end else begin
                        d_state_d = DONE;
                        d_data_d  = {w_lb[4], w_lb[3]};
                        d_err_d   = |w_lerr[4:3];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_state_q <= IDLE;
            i_cnt_q   <= 3'd0;
            i_addr_q  <= 16'h0000;
            i_data_q  <= 24'h000000;
            i_err_q   <= 1'b0;
            d_state_q <= IDLE;
            d_cnt_q   <= 3'd0;
            d_addr_q  <= 16'h0000;
            d_data_q  <= 16'h0000;
            d_err_q   <= 1'b0;
            werr_q    <= 1'b0;
        end else begin
            i_state_q <= i_state_d;
            i_cnt_q   <= i_cnt_d;
            i_addr_q  <= i_addr_d;
            i_data_q  <= i_data_d;
            i_err_q   <= i_err_d;
            d_state_q <= d_state_d;
            d_cnt_q   <= d_cnt_d;
            d_addr_q  <= d_addr_d;
            d_data_q  <= d_data_d;
            d_err_q   <= d_err_d;
            werr_q    <= werr_d;
        end
    end

    assign iread_ready = (i_state_q != BUSY);
    assign iread_valid = (i_state_q == DONE);
    assign iread_err   = (i_state_q == DONE) && i_err_q;
    assign iread_data  = i_data_q;
    assign dread_ready = (d_state_q != BUSY);
    assign dread_valid = (d_state_q == DONE);
    assign dread_err   = (d_state_q == DONE) && d_err_q;
    assign dread_data  = d_data_q;
    assign dwrite_err  = werr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl with ROMWAIT=3 and the default address map.
`default_nettype none

module tb_mem_ctrl;

    localparam int ROMWAIT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iread_req = 1'b0;
    logic        iread_ready;
    logic [15:0] iread_addr = 16'h0000;
    logic [23:0] iread_data;
    logic        iread_valid;
    logic        iread_err;
    logic        dread_req = 1'b0;
    logic        dread_ready;
    logic [15:0] dread_addr = 16'h0000;
    logic [15:0] dread_data;
    logic        dread_valid;
    logic        dread_err;
    logic [15:0] dwrite_addr = 16'h0000;
    logic [15:0] dwrite_data = 16'h0000;
    logic [1:0]  dwrite_en = 2'b00;
    logic        dwrite_err;

    always #5 clk = ~clk;

    mem_ctrl #(
        .RAMADDRBITS(10),
        .RAMBASE    (16'h0000),
        .ROMSIZE    (2048),
        .ROMBASE    (16'h4000),
        .ROMWAIT    (ROMWAIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .iread_req  (iread_req),
        .iread_ready(iread_ready),
        .iread_addr (iread_addr),
        .iread_data (iread_data),
        .iread_valid(iread_valid),
        .iread_err  (iread_err),
        .dread_req  (dread_req),
        .dread_ready(dread_ready),
        .dread_addr (dread_addr),
        .dread_data (dread_data),
        .dread_valid(dread_valid),
        .dread_err  (dread_err),
        .dwrite_addr(dwrite_addr),
        .dwrite_data(dwrite_data),
        .dwrite_en  (dwrite_en),
        .dwrite_err (dwrite_err)
    );

    typedef struct {
        logic [23:0] d;
        logic        e;
        int          c;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];
    logic [7:0] model [1024];
    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic is_ram(input logic [15:0] a);
        return a < 16'h0400;
    endfunction

    // {err, byte} for one address from the bench's own view of the memory map.
    function automatic logic [8:0] exp_byte(input logic [15:0] a);
        logic [15:0] off;
        if (is_ram(a)) return {1'b0, model[a[9:0]]};
        if (a >= 16'h4000 && a < 16'h4800) begin
            off = a - 16'h4000;
            return {1'b0, off[7:0] ^ {5'b0, off[10:8]} ^ 8'hA5};
        end
        return 9'h100;
    endfunction

    function automatic logic is_rom(input logic [15:0] a);
        return a >= 16'h4000 && a < 16'h4800;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_i(input logic [15:0] a);
        logic [15:0] a1, a2;
        logic [8:0]  b0, b1, b2;
        int lat;
        a1 = a + 16'd1;
        a2 = a + 16'd2;
        b0 = exp_byte(a);
        b1 = exp_byte(a1);
        b2 = exp_byte(a2);
        lat = (is_rom(a) || is_rom(a1) || is_rom(a2)) ? 1 + ROMWAIT : 1;
        iq.push_back('{d: {b2[7:0], b1[7:0], b0[7:0]}, e: b0[8] | b1[8] | b2[8], c: cyc + lat});
        iread_req  = 1'b1;
        iread_addr = a;
    endtask

    task automatic push_d(input logic [15:0] a);
        logic [15:0] a1;
        logic [8:0]  b0, b1;
        int lat;
        a1 = a + 16'd1;
        b0 = exp_byte(a);
        b1 = exp_byte(a1);
        lat = (is_rom(a) || is_rom(a1)) ? 1 + ROMWAIT : 1;
        dq.push_back('{d: {8'h00, b1[7:0], b0[7:0]}, e: b0[8] | b1[8], c: cyc + lat});
        dread_req  = 1'b1;
        dread_addr = a;
    endtask

    task automatic model_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] en);
        logic [15:0] a1;
        a1 = a + 16'd1;
        if (en[0] && is_ram(a))  model[a[9:0]]  = d[7:0];
        if (en[1] && is_ram(a1)) model[a1[9:0]] = d[15:8];
        dwrite_addr = a;
        dwrite_data = d;
        dwrite_en   = en;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] en);
        logic [15:0] a1;
        logic        e;
        a1 = a + 16'd1;
        e  = (en[0] && !is_ram(a)) || (en[1] && !is_ram(a1));
        model_write(a, d, en);
        step();
        dwrite_en = 2'b00;
        chk("wr_err_pulse", {31'b0, dwrite_err}, {31'b0, e});
        step();
        chk("wr_err_clear", {31'b0, dwrite_err}, 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((iq.size() != 0 || dq.size() != 0) && n < 40) begin
            step();
            n++;
        end
        if (iq.size() != 0 || dq.size() != 0)
            chk("drain_timeout", iq.size() + dq.size(), 32'd0);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (iread_valid) begin
            if (iq.size() == 0) begin
                chk("i_valid_unexpected", 32'd1, 32'd0);
            end else begin
                e = iq.pop_front();
                chk("i_data", {8'h00, iread_data}, {8'h00, e.d});
                chk("i_err", {31'b0, iread_err}, {31'b0, e.e});
                chk("i_latency_cycle", cyc, e.c);
            end
        end
        if (dread_valid) begin
            if (dq.size() == 0) begin
                chk("d_valid_unexpected", 32'd1, 32'd0);
            end else begin
                e = dq.pop_front();
                chk("d_data", {16'h0000, dread_data}, {16'h0000, e.d[15:0]});
                chk("d_err", {31'b0, dread_err}, {31'b0, e.e});
                chk("d_latency_cycle", cyc, e.c);
            end
        end
    end

    initial begin
        repeat (3) step();
        chk("rst_iready", {31'b0, iread_ready}, 32'd1);
        chk("rst_dready", {31'b0, dread_ready}, 32'd1);
        chk("rst_ivalid", {31'b0, iread_valid}, 32'd0);
        chk("rst_dvalid", {31'b0, dread_valid}, 32'd0);
        chk("rst_ierr", {31'b0, iread_err}, 32'd0);
        chk("rst_derr", {31'b0, dread_err}, 32'd0);
        chk("rst_werr", {31'b0, dwrite_err}, 32'd0);
        chk("rst_idata", {8'h00, iread_data}, 32'd0);
        chk("rst_ddata", {16'h0000, dread_data}, 32'd0);

        // ROM fetch right after reset release, ready low through the wait states
        reset = 1'b0;
        push_i(16'h4000);
        step();
        iread_req = 1'b0;
        for (int i = 0; i < ROMWAIT; i++) begin
            chk("i_ready_busy", {31'b0, iread_ready}, 32'd0);
            step();
        end
        chk("i_ready_done", {31'b0, iread_ready}, 32'd1);
        drain();

        // RAM round trip and partial write
        wr(16'h0010, 16'hBEEF, 2'b11);
        push_d(16'h0010); step(); dread_req = 1'b0; drain();
        wr(16'h0010, 16'h1234, 2'b01);
        push_d(16'h0010); step(); dread_req = 1'b0; drain();

        // back-to-back data reads
        wr(16'h0000, 16'h2211, 2'b11);
        wr(16'h0002, 16'h4433, 2'b11);
        wr(16'h0004, 16'h6655, 2'b11);
        push_d(16'h0000); step();
        push_d(16'h0002); step();
        push_d(16'h0004); step();
        dread_req = 1'b0;
        drain();

        // errors and boundaries
        push_d(16'h8000); step(); dread_req = 1'b0; drain();
        wr(16'h4002, 16'hFFFF, 2'b11);
        push_i(16'h4002); step(); iread_req = 1'b0; drain();
        wr(16'h03FE, 16'hC0DE, 2'b11);
        wr(16'h03FF, 16'h77AA, 2'b11);
        push_i(16'h03FF); step(); iread_req = 1'b0; drain();
        wr(16'h0040, 16'h1234, 2'b00);
        push_i(16'hFFFF); step(); iread_req = 1'b0; drain();
        push_i(16'h47FF); step(); iread_req = 1'b0; drain();
        push_d(16'h47FF); step(); dread_req = 1'b0; drain();

        // concurrent ROM fetch and RAM read
        push_i(16'h4010);
        push_d(16'h0002);
        step();
        iread_req = 1'b0;
        dread_req = 1'b0;
        drain();

        // write-first forwarding on both ports
        wr(16'h0020, 16'h5566, 2'b11);
        model_write(16'h0020, 16'hA1B2, 2'b01);
        push_d(16'h0020);
        step();
        dread_req = 1'b0;
        dwrite_en = 2'b00;
        drain();
        wr(16'h0030, 16'h9988, 2'b11);
        wr(16'h0032, 16'h00CC, 2'b01);
        model_write(16'h0031, 16'h00EE, 2'b01);
        push_i(16'h0030);
        step();
        iread_req = 1'b0;
        dwrite_en = 2'b00;
        drain();

        // reset during ROM wait states aborts the fetch
        push_i(16'h4000);
        step();
        iread_req = 1'b0;
        step();
        reset = 1'b1;
        iq.delete();
        step();
        step();
        reset = 1'b0;
        chk("i_ready_after_reset", {31'b0, iread_ready}, 32'd1);
        push_i(16'h4005);
        step();
        iread_req = 1'b0;
        drain();
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule

`default_nettype wire
